// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, control-register bit positions, frame width.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned FRAME_WIDTH = 8;

  localparam int unsigned CR_UE  = 0;
  localparam int unsigned CR_PCE = 4;
  localparam int unsigned CR_PS  = 5;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t StIdle   = 3'd0;
  localparam uart_state_t StStart  = 3'd1;
  localparam uart_state_t StData   = 3'd2;
  localparam uart_state_t StParity = 3'd3;
  localparam uart_state_t StStop   = 3'd4;

  // odd=0 gives even parity, odd=1 gives odd parity over the data byte.
  function automatic logic parity_bit(input logic [FRAME_WIDTH-1:0] data, input logic odd);
    return odd ^ (^data);
  endfunction

endpackage

// File: rtl/uart_transmit.sv
// UART transmit engine: one-byte holding register, LSB-first shifter, start/data/[parity]/stop.
// The parity bit is only built when UART_TX_PARITY_EN is defined; otherwise frames are 10 bits.
module uart_transmit
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  uart_cr_i,
  input  logic [15:0] uart_brr_i,
  input  logic [7:0]  data_i,
  input  logic        we_i,
  output logic        txe_o,
  output logic        tc_o,
  input  logic        baud_clk_i,
  output logic        baudgenerator_en_o,
  output logic        tx_o
);

  uart_state_t            state_q, state_d;
  logic [FRAME_WIDTH-1:0] tdr_q, tdr_d;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   txe_q, txe_d;
  logic                   tx_q, tx_d;
  logic                   en_q, en_d;
  logic                   start_ok;
  logic                   load;

  // A frame may begin only with a full holding register and the UART enabled.
  assign start_ok = uart_cr_i[CR_UE] & ~txe_q;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
  logic unused_cr;
  assign unused_cr = ^{uart_brr_i, uart_cr_i[3:1]};
`else
  logic unused_cr;
  assign unused_cr = ^{uart_brr_i, uart_cr_i[5:1]};
`endif

  always_comb begin
    state_d = state_q;
    tdr_d   = tdr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    txe_d   = txe_q;
    tx_d    = tx_q;
    en_d    = en_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        en_d = 1'b0;
        if (start_ok) load = 1'b1;
      end
      StStart: begin
        if (baud_clk_i) begin
          tx_d    = shift_q[0];
          cnt_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_clk_i) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'(FRAME_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_clk_i) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (baud_clk_i) begin
          if (start_ok) begin
            load = 1'b1;
          end else begin
            en_d    = 1'b0;
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        en_d    = 1'b0;
      end
    endcase

    // Frame configuration is captured here and held until the next load.
    if (load) begin
      shift_d = tdr_q;
      txe_d   = 1'b1;
      tx_d    = 1'b0;
      en_d    = 1'b1;
      state_d = StStart;
`ifdef UART_TX_PARITY_EN
      par_en_d  = uart_cr_i[CR_PCE];
      par_bit_d = parity_bit(tdr_q, uart_cr_i[CR_PS]);
`endif
    end

    // load requires txe_q=0, so it never collides with an accepted write.
    if (we_i && txe_q) begin
      tdr_d = data_i;
      txe_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      tdr_q   <= '0;
      shift_q <= '0;
      cnt_q   <= 3'd0;
      txe_q   <= 1'b1;
      tx_q    <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tdr_q   <= tdr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      txe_q   <= txe_d;
      tx_q    <= tx_d;
      en_q    <= en_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`endif

  assign txe_o              = txe_q;
  assign tc_o               = (state_q == StIdle) & txe_q;
  assign tx_o               = tx_q;
  assign baudgenerator_en_o = en_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: directed writes queue expected frames; a line monitor decodes tx
// at mid-bit and compares against the queue. A local baud generator model drives baud_clk_i.
module tb_uart_transmit;

  localparam int Brr = 16;
`ifdef UART_TX_PARITY_EN
  localparam int ParityBuilt = 1;
`else
  localparam int ParityBuilt = 0;
`endif

  typedef struct packed {
    logic [7:0] b;
    logic       has_par;
    logic       par;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  cr;
  logic [15:0] brr;
  logic [7:0]  data;
  logic        we;
  logic        txe, tc, baud_tick, baud_en, tx;
  logic [15:0] bcnt;

  int     n_vec = 0;
  int     n_err = 0;
  bit     mon_en = 1'b0;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  uart_transmit dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .uart_cr_i          (cr),
    .uart_brr_i         (brr),
    .data_i             (data),
    .we_i               (we),
    .txe_o              (txe),
    .tc_o               (tc),
    .baud_clk_i         (baud_tick),
    .baudgenerator_en_o (baud_en),
    .tx_o               (tx)
  );

  // Baud generator: first tick Brr clocks after enable rises, then every Brr clocks.
  always_ff @(posedge clk) begin
    if (rst || !baud_en)      bcnt <= '0;
    else if (bcnt == brr - 1) bcnt <= '0;
    else                      bcnt <= bcnt + 16'd1;
  end
  assign baud_tick = baud_en && (bcnt == brr - 1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic pce, input logic par);
    frame_t f;
    f.b       = b;
    f.has_par = (ParityBuilt != 0) && pce;
    f.par     = par;
    exp_q.push_back(f);
  endtask

  // Leaves the caller at the negedge one cycle after the write strobe.
  task automatic write_byte(input logic [7:0] b);
    we   = 1'b1;
    data = b;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic wait_tc(input string name, input int expected);
    int n = 0;
    while (tc !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, n, expected);
  endtask

  // Line monitor
  initial begin
    frame_t     e;
    logic [7:0] got;
    logic       st, pb, sb;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (Brr / 2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (Brr) @(negedge clk);
          got[i] = tx;
        end
        check("frame expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("start bit", st, 0);
          check("data byte", got, e.b);
          if (e.has_par) begin
            repeat (Brr) @(negedge clk);
            pb = tx;
            check("parity bit", pb, e.par);
          end
          repeat (Brr) @(negedge clk);
          sb = tx;
          check("stop bit", sb, 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_low;
    rst  = 1'b1;
    cr   = 6'h00;
    brr  = 16'(Brr);
    data = 8'h00;
    we   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset txe", txe, 1);
    check("reset tc", tc, 1);
    check("reset baud_en", baud_en, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Basic frame
    cr = 6'h01;
    @(negedge clk);
    write_byte(8'hA5);
    expect_frame(8'hA5, 1'b0, 1'b0);
    check("basic txe N+1", txe, 0);
    @(negedge clk);
    check("basic tx N+2", tx, 0);
    check("basic en N+2", baud_en, 1);
    check("basic txe N+2", txe, 1);
    check("basic tc N+2", tc, 0);
    wait_tc("basic frame length", 160);

    // Even parity: 0x07 has three ones -> parity bit 1
    cr = 6'h11;
    @(negedge clk);
    write_byte(8'h07);
    expect_frame(8'h07, 1'b1, 1'b1);
    @(negedge clk);
    check("even tx start", tx, 0);
    wait_tc("even frame length", (ParityBuilt != 0) ? 176 : 160);

    // Odd parity -> parity bit 0
    cr = 6'h31;
    @(negedge clk);
    write_byte(8'h07);
    expect_frame(8'h07, 1'b1, 1'b0);
    @(negedge clk);
    check("odd tx start", tx, 0);
    wait_tc("odd frame length", (ParityBuilt != 0) ? 176 : 160);

    // Back-to-back: two frames with no idle gap, tc low throughout
    cr = 6'h01;
    @(negedge clk);
    write_byte(8'h55);
    expect_frame(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b txe before 2nd", txe, 1);
    write_byte(8'hAA);
    expect_frame(8'hAA, 1'b0, 1'b0);
    check("b2b txe after 2nd", txe, 0);
    wait_tc("b2b total length", 319);

    // Overrun: 0x22 arrives while txe=0 and is dropped
    @(negedge clk);
    write_byte(8'h11);
    expect_frame(8'h11, 1'b0, 1'b0);
    check("overrun txe at 2nd write", txe, 0);
    we   = 1'b1;
    data = 8'h22;
    @(negedge clk);
    we   = 1'b0;
    check("overrun tx start", tx, 0);
    write_byte(8'h33);
    expect_frame(8'h33, 1'b0, 1'b0);
    wait_tc("overrun total length", 319);

    // UE gating
    cr = 6'h00;
    @(negedge clk);
    write_byte(8'h3C);
    saw_low = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1 || txe !== 1'b0) saw_low = 1'b1;
    end
    check("ue gated line idle", saw_low, 0);
    check("ue gated txe", txe, 0);
    cr = 6'h01;
    @(negedge clk);
    expect_frame(8'h3C, 1'b0, 1'b0);
    check("ue start after enable", tx, 0);
    wait_tc("ue frame length", 160);

    // Reset mid-frame during data bit 3, with the TDR also full
    mon_en = 1'b0;
    @(negedge clk);
    write_byte(8'h5A);
    @(negedge clk);
    check("rst test frame started", tx, 0);
    repeat (70) @(negedge clk);
    write_byte(8'hC3);
    check("rst test tdr full", txe, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst tx", tx, 1);
    check("midrst en", baud_en, 0);
    check("midrst txe", txe, 1);
    check("midrst tc", tc, 1);
    saw_low = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("after rst line idle", saw_low, 0);

    // Recovery frame after reset
    mon_en = 1'b1;
    write_byte(8'h81);
    expect_frame(8'h81, 1'b0, 1'b0);
    @(negedge clk);
    wait_tc("recovery frame length", 160);
    repeat (4) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
